// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - stores a move program and replays it as one-hot n/s/e/w pulses into the game FSM
module move_sequencer #(
  parameter int  DEPTH = 16,
  parameter int  GAP   = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [1:0]    load_dir,
  output logic          load_ready,
  input  logic          flush,
  input  logic          start,
  input  logic          clear,
  input  logic          d,
  input  logic          win,
  output logic          game_reset,
  output logic          n,
  output logic          s,
  output logic          e,
  output logic          w,
  output logic          busy,
  output logic          done,
  output logic [1:0]    result,
  output logic [CW-1:0] count,
  output logic [CW-1:0] moves_issued
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = $clog2(GAP + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_C   = GW'(GAP);
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_DEAD = 2'b10;
  localparam logic [1:0] RES_EXH  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_GRST, S_ISSUE, S_GAP, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    mem [DEPTH];
  logic [CW-1:0] rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    cur_dir;
  logic          has_room, outcome, gap_last, more, load_fire;

  assign has_room  = count < DEPTH_C;
  assign outcome   = win | d;
  assign gap_last  = gap_cnt == GW'(1);
  assign more      = rd_ptr < count;
  assign cur_dir   = mem[rd_ptr[AW-1:0]];
  // flush and start both outrank a coincident load
  assign load_fire = (state == S_IDLE) && !flush && !start && load_valid && has_room;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (!flush && start) state_nxt = (count == '0) ? S_DONE : S_GRST;
      S_GRST:  state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = outcome ? S_DONE : S_GAP;
      S_GAP:
        if (outcome)       state_nxt = S_DONE;
        else if (gap_last) state_nxt = more ? S_ISSUE : S_DONE;
      S_DONE:
        if (clear) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    game_reset = 1'b0;
    n = 1'b0; s = 1'b0; e = 1'b0; w = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE: load_ready = has_room;
      S_GRST: begin game_reset = 1'b1; busy = 1'b1; end
      S_ISSUE: begin
        busy = 1'b1;
        case (cur_dir)
          2'b00:   n = 1'b1;
          2'b01:   s = 1'b1;
          2'b10:   e = 1'b1;
          default: w = 1'b1;
        endcase
      end
      S_GAP:  busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // win outranks dead when both are seen in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      rd_ptr       <= '0;
      moves_issued <= '0;
      result       <= RES_NONE;
      gap_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (flush) begin
            count        <= '0;
            moves_issued <= '0;
          end else if (start) begin
            if (count == '0) result <= RES_EXH;
            else begin
              rd_ptr       <= '0;
              moves_issued <= '0;
            end
          end else if (load_fire) begin
            count <= count + 1'b1;
          end
        S_ISSUE: begin
          rd_ptr       <= rd_ptr + 1'b1;
          moves_issued <= moves_issued + 1'b1;
          gap_cnt      <= GAP_C;
          if (win)    result <= RES_WIN;
          else if (d) result <= RES_DEAD;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (win)                     result <= RES_WIN;
          else if (d)                  result <= RES_DEAD;
          else if (gap_last && !more)  result <= RES_EXH;
        end
        S_DONE:
          if (clear) result <= RES_NONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) mem[count[AW-1:0]] <= load_dir;
  end

endmodule
